tick_monitor: RTL and testbench

TICK_MONITOR -- requirements
Module: tick_monitor

---
 rtl/tick_monitor_if.sv | 24 ++
 rtl/tick_monitor.sv | 160 ++++++++++++++++
 tb/tb_tick_monitor.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tick_monitor_if.sv
// Tick monitor bus: upstream tick/error/clear in, measurement and status out.
interface tick_monitor_if #(
    parameter int unsigned CBITS = 14
);
    logic              tick;
    logic              up_err;
    logic              clear;
    logic [CBITS:0]    period;
    logic [15:0]       tick_cnt;
    logic              locked;
    logic              err;

    // Driver side (stimulus / upstream + status consumer)
    modport master (
        output tick, up_err, clear,
        input  period, tick_cnt, locked, err
    );

    // Monitor side
    modport slave (
        input  tick, up_err, clear,
        output period, tick_cnt, locked, err
    );
endinterface

// File: rtl/tick_monitor.sv
// Tick monitor: measures the interval between upstream period ticks, locks
// after LOCK_CNT consecutive in-window ticks and flags early/missing ticks.
// Optional macro TICK_MON_STICKY_ERR_EN: err holds in FAULT until clear/reset;
// otherwise err pulses one cycle and FAULT falls back to IDLE.
module tick_monitor #(
    parameter int unsigned N        = 10000,
    parameter int unsigned CBITS    = 14,
    parameter int unsigned TOL      = 2,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic           clk,
    input  logic           rst,
    tick_monitor_if.slave  bus
);

    localparam int unsigned W  = CBITS + 1;
    localparam int unsigned MW = W + 1;
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned P  = N + 1;

    localparam logic [MW-1:0] P_LO = MW'(P - TOL);
    localparam logic [MW-1:0] P_HI = MW'(P + TOL);
    localparam logic [MW-1:0] P_TO = MW'(P + TOL + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [1:0] FAULT   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  ivl_q, ivl_d;
    logic [GW-1:0] good_q, good_d;
    logic [W-1:0]  period_q, period_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;

    logic [MW-1:0] meas;
    logic [W-1:0]  meas_sat;
    logic          ivl_max;
    logic          is_good;
    logic          timeout;

    // Interval classification against the expected period window
    always_comb begin
        ivl_max  = &ivl_q;
        meas     = {1'b0, ivl_q} + MW'(1);
        meas_sat = ivl_max ? '1 : W'(meas);
        is_good  = (meas >= P_LO) && (meas <= P_HI);
        // ivl steps by one per cycle, so equality fires exactly once per gap
        timeout  = !bus.tick && (meas == P_TO);
    end

    // Next-state, counters and registered output values
    always_comb begin
        state_d  = state_q;
        ivl_d    = ivl_max ? ivl_q : ivl_q + W'(1);
        good_d   = good_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        locked_d = 1'b0;
        err_d    = 1'b0;

        if (bus.tick) begin
            ivl_d = '0;
            cnt_d = cnt_q + 16'd1;
            if (state_q != IDLE) begin
                period_d = meas_sat;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.tick) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE: begin
                if (bus.up_err) begin
                    state_d = FAULT;
                end else if (timeout) begin
                    state_d = IDLE;
                    good_d  = '0;
                end else if (bus.tick) begin
                    if (is_good) begin
                        good_d = good_q + GW'(1);
                        if (good_q == GW'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (bus.up_err || timeout || (bus.tick && !is_good)) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
`ifdef TICK_MON_STICKY_ERR_EN
                state_d = FAULT;
`else
                state_d = IDLE;
                good_d  = '0;
`endif
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
`ifdef TICK_MON_STICKY_ERR_EN
        err_d    = (state_d == FAULT);
`else
        err_d    = (state_d == FAULT) && (state_q != FAULT);
`endif

        // Clear restarts the monitor and swallows a same-cycle tick
        if (bus.clear) begin
            state_d  = IDLE;
            good_d   = '0;
            ivl_d    = '0;
            period_d = period_q;
            cnt_d    = cnt_q;
            locked_d = 1'b0;
            err_d    = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ivl_q    <= '0;
            good_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ivl_q    <= ivl_d;
            good_q   <= good_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign bus.period   = period_q;
    assign bus.tick_cnt = cnt_q;
    assign bus.locked   = locked_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Directed bench for tick_monitor (N=10 -> P=11, TOL=1, LOCK_CNT=4).
module tb_tick_monitor;

    localparam int unsigned N        = 10;
    localparam int unsigned CBITS    = 4;
    localparam int unsigned TOL      = 1;
    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned W        = CBITS + 1;

`ifdef TICK_MON_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    tick_monitor_if #(.CBITS(CBITS)) bus ();

    tick_monitor #(
        .N        (N),
        .CBITS    (CBITS),
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        logic [W-1:0]   period;
        logic [15:0]    cnt;
        logic           locked;
        logic           err;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_per = '0;
    logic [15:0]  exp_cnt = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic lk, input logic er);
        exp_t e;
        e.tag    = tag;
        e.period = exp_per;
        e.cnt    = exp_cnt;
        e.locked = lk;
        e.err    = er;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: got size %0d expected nonzero", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (bus.period === e.period) else begin
                errors++;
                $error("FAIL %s.period got %0d expected %0d", e.tag, bus.period, e.period);
            end
            checks++;
            assert (bus.tick_cnt === e.cnt) else begin
                errors++;
                $error("FAIL %s.tick_cnt got %0d expected %0d", e.tag, bus.tick_cnt, e.cnt);
            end
            checks++;
            assert (bus.locked === e.locked) else begin
                errors++;
                $error("FAIL %s.locked got %b expected %b", e.tag, bus.locked, e.locked);
            end
            checks++;
            assert (bus.err === e.err) else begin
                errors++;
                $error("FAIL %s.err got %b expected %b", e.tag, bus.err, e.err);
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        bus.tick = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Tick exactly gap cycles after the previous one; upd says whether
    // the monitor is out of IDLE and therefore records the interval
    task automatic send_tick(input int gap, input bit upd, input logic lk,
                             input logic er, input string tag);
        idle_cycles(gap - 1);
        bus.tick = 1'b1;
        exp_cnt  = exp_cnt + 16'd1;
        if (upd) exp_per = W'(gap);
        push(tag, lk, er);
        step();
        bus.tick = 1'b0;
        check_pop();
    endtask

    task automatic do_clear(input string tag);
        bus.clear = 1'b1;
        push(tag, 1'b0, 1'b0);
        step();
        bus.clear = 1'b0;
        check_pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.tick   = 1'b0;
        bus.up_err = 1'b0;
        bus.clear  = 1'b0;
        rst        = 1'b1;
        #1 rst     = 1'b0;
        #1;
        push("reset", 1'b0, 1'b0);
        check_pop();
        step();
        step();
        rst = 1'b1;

        // up_err is ignored in IDLE
        bus.up_err = 1'b1;
        push("uperr_idle", 1'b0, 1'b0);
        step();
        bus.up_err = 1'b0;
        check_pop();

        // Lock: first tick leaves period alone, window edges 10 and 12 are good
        send_tick(3,  1'b0, 1'b0, 1'b0, "first");
        send_tick(11, 1'b1, 1'b0, 1'b0, "m1");
        send_tick(10, 1'b1, 1'b0, 1'b0, "m2_lo");
        send_tick(12, 1'b1, 1'b0, 1'b0, "m3_hi");
        send_tick(11, 1'b1, 1'b1, 1'b0, "lock");
        send_tick(11, 1'b1, 1'b1, 1'b0, "locked_hold");

        // Early tick while locked
        send_tick(8, 1'b1, 1'b0, 1'b1, "early_fault");
        push("fault_next", 1'b0, STICKY);
        step();
        check_pop();

        // Clear beats a same-cycle tick
        bus.clear = 1'b1;
        bus.tick  = 1'b1;
        push("clear_tick", 1'b0, 1'b0);
        step();
        bus.clear = 1'b0;
        bus.tick  = 1'b0;
        check_pop();

        // Restart; early tick in MEASURE zeroes the good run
        send_tick(4,  1'b0, 1'b0, 1'b0, "restart");
        send_tick(11, 1'b1, 1'b0, 1'b0, "r1");
        send_tick(11, 1'b1, 1'b0, 1'b0, "r2");
        send_tick(7,  1'b1, 1'b0, 1'b0, "early_meas");
        for (int i = 0; i < 4; i++) begin
            send_tick(11, 1'b1, logic'(i == 3), 1'b0, $sformatf("relock%0d", i));
        end

        // Withheld tick: last in-window cycle then timeout
        idle_cycles(11);
        push("pre_timeout", 1'b1, 1'b0);
        step();
        check_pop();
        push("timeout", 1'b0, 1'b1);
        step();
        check_pop();
        push("timeout_next", 1'b0, STICKY);
        step();
        check_pop();
        do_clear("clear");

        // Timeout in MEASURE returns to IDLE: next tick does not record period
        send_tick(2, 1'b0, 1'b0, 1'b0, "meas_start");
        idle_cycles(20);
        send_tick(2, 1'b0, 1'b0, 1'b0, "after_meas_timeout");
        for (int i = 0; i < 4; i++) begin
            send_tick(11, 1'b1, logic'(i == 3), 1'b0, $sformatf("lock_b%0d", i));
        end

        // Asynchronous reset between edges
        #3 rst = 1'b0;
        #1;
        exp_per = '0;
        exp_cnt = '0;
        push("async_reset", 1'b0, 1'b0);
        check_pop();
        #2 rst = 1'b1;
        send_tick(3, 1'b0, 1'b0, 1'b0, "post_rst_first");
        for (int i = 0; i < 4; i++) begin
            send_tick(11, 1'b1, logic'(i == 3), 1'b0, $sformatf("post_rst%0d", i));
        end

        // up_err while locked
        bus.up_err = 1'b1;
        push("uperr_locked", 1'b0, 1'b1);
        step();
        bus.up_err = 1'b0;
        check_pop();
        do_clear("clear2");

        // up_err while measuring
        send_tick(3, 1'b0, 1'b0, 1'b0, "meas_again");
        bus.up_err = 1'b1;
        push("uperr_meas", 1'b0, 1'b1);
        step();
        bus.up_err = 1'b0;
        check_pop();
        do_clear("clear3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
